// File: rtl/mips_mem_responder.sv
// -----------------------------------------------------------------------------
// mips_mem_responder
//
// Purpose: single-outstanding memory responder for a MIPS-style initiator.
// It accepts one load/store request, waits WAIT_STATES cycles, then presents
// the response and holds it until the initiator takes it. The storage is a
// DEPTH x 32-bit word array. A store is written to the array on the edge that
// enters RESP. Its data is echoed back as the response data.
//
// Parameters:
//   DEPTH        number of 32-bit words stored (default 1024)
//   WAIT_STATES  extra cycles between accept and response, 0..15 (default 2)
//
// Ports:
//   clk1        in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  responder can accept (IDLE only)
//   req_we      in   1 = store, 0 = load/fetch
//   req_addr    in   32-bit word address
//   req_wdata   in   32-bit store data
//   resp_valid  out  response present (RESP only)
//   resp_ready  in   initiator takes the response
//   resp_rdata  out  load data, or echoed store data
//   resp_err    out  address error flag, qualified by resp_valid
//
// Optional feature: define MIPS_MEM_RESP_ADDR_CHECK_EN to flag addresses
// >= DEPTH with resp_err=1. In that case the store is suppressed and
// resp_rdata is 0. Without the macro, addresses wrap modulo DEPTH and
// resp_err is always 0.
// -----------------------------------------------------------------------------
module mips_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Latched transaction
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic [31:0] mem [DEPTH];

  // Address decode of the incoming request
  logic [AW-1:0] req_idx_d;
  logic          req_err_d;

`ifdef MIPS_MEM_RESP_ADDR_CHECK_EN
  assign req_err_d = (req_addr >= 32'(DEPTH));
  assign req_idx_d = AW'(req_addr);
`else
  assign req_err_d = 1'b0;
  assign req_idx_d = AW'(req_addr % 32'(DEPTH));
`endif

  logic accept;
  assign accept = (state_q == IDLE) && req_ready_q && req_valid;

  // The transaction that enters RESP on this edge. It is the live request
  // when WAIT_STATES=0, because the accept and RESP entry share one edge.
  // Otherwise it is the latched copy.
  logic          txn_we;
  logic [AW-1:0] txn_idx;
  logic [31:0]   txn_wdata;
  logic          txn_err;

  always_comb begin
    txn_we    = we_q;
    txn_idx   = idx_q;
    txn_wdata = wdata_q;
    txn_err   = err_q;
    if (state_q == IDLE) begin
      txn_we    = req_we;
      txn_idx   = req_idx_d;
      txn_wdata = req_wdata;
      txn_err   = req_err_d;
    end
  end

  logic enter_resp;
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  // The store commits only on the RESP-entry edge. A reset during WAIT
  // drops state_q to IDLE, so an interrupted store never reaches here.
  logic mem_we;
  assign mem_we = enter_resp && txn_we && !txn_err;

  always_ff @(posedge clk1) begin
    if (mem_we) begin
      mem[txn_idx] <= txn_wdata;
    end
  end

  logic [31:0] mem_rd;
  logic [31:0] rdata_d;
  assign mem_rd  = mem[txn_idx];
  assign rdata_d = txn_err ? 32'd0 : (txn_we ? txn_wdata : mem_rd);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready is registered. It therefore rises on the first edge
          // after reset is released.
          req_ready_q <= 1'b1;
          if (accept) begin
            we_q        <= req_we;
            idx_q       <= req_idx_d;
            wdata_q     <= req_wdata;
            err_q       <= req_err_d;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= txn_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= txn_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_responder
//
// Two responders share one clock and one reset:
//   dut 0  WAIT_STATES=2, DEPTH=1024
//   dut 1  WAIT_STATES=0, DEPTH=1024
//
// A vector table of load/store transactions is applied to dut 0. Each entry
// carries its expected response. The expected response is pushed to a
// scoreboard queue when the request is driven. It is popped when the DUT
// presents the response. Hand-written sequences follow for reset during
// WAIT, a request arriving during WAIT, and zero wait states.
// -----------------------------------------------------------------------------
module tb_mips_mem_responder;

  localparam int DEPTH = 1024;

`ifdef MIPS_MEM_RESP_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mips_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_STATES ((gi == 0) ? 2 : 0)
      ) u_dut (
        .clk1       (clk),
        .rst        (rst),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_we     (req_we[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .resp_valid (resp_valid[gi]),
        .resp_ready (resp_ready[gi]),
        .resp_rdata (resp_rdata[gi]),
        .resp_err   (resp_err[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int ws(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_reset_outputs(input int s, input string tag);
    chk({tag, "_valid"}, {31'd0, resp_valid[s]}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata[s], 32'd0);
    chk({tag, "_err"},   {31'd0, resp_err[s]},   32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready[s]},  32'd0);
  endtask

  // Run one transaction on dut s. If intrude is set, req_valid is held high
  // while the DUT waits. The extra request is a store to addr+1 with junk
  // data, and it must be ignored.
  task automatic do_txn(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input bit intrude);
    int   k;
    exp_t e;
    @(negedge clk);
    k = 0;
    while (!req_ready[s] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[s]) begin
      chk("ready_wait_timeout", {31'd0, req_ready[s]}, 32'd1);
      return;
    end
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1;
    if (intrude) begin
      req_we[s]    = 1'b1;
      req_addr[s]  = addr + 32'd1;
      req_wdata[s] = 32'h0BAD_0BAD;
    end else begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'($urandom);
      req_addr[s]  = 32'($urandom);
      req_wdata[s] = 32'($urandom);
    end
    k = 0;
    @(negedge clk);
    while (!resp_valid[s] && k < 50) begin
      chk("ready_busy", {31'd0, req_ready[s]}, 32'd0);
      @(negedge clk);
      k++;
    end
    req_valid[s] = 1'b0;
    chk("latency", 32'(k), 32'(ws(s)));
    if (!resp_valid[s]) begin
      void'(sb.pop_front());
      return;
    end
    chk("ready_in_resp", {31'd0, req_ready[s]}, 32'd0);
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid[s]}, 32'd1);
      chk("hold_rdata", resp_rdata[s], e.rdata);
      chk("hold_ready", {31'd0, req_ready[s]}, 32'd0);
    end
    chk("rdata", resp_rdata[s], e.rdata);
    chk("err", {31'd0, resp_err[s]}, {31'd0, e.err});
    $display("txn dut%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d hold=%0d",
             s, we, addr, wdata, resp_rdata[s], resp_err[s], k, hold);
    resp_ready[s] = 1'b1;
    @(negedge clk);
    resp_ready[s] = 1'b0;
    chk("valid_drop", {31'd0, resp_valid[s]}, 32'd0);
    chk("ready_back", {31'd0, req_ready[s]}, 32'd1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      req_we[s]     = 1'b0;
      req_addr[s]   = 32'd0;
      req_wdata[s]  = 32'd0;
      resp_ready[s] = 1'b0;
    end

    // Vector table: {we, addr, wdata, exp_rdata, exp_err, hold}
    vecs[0]  = '{1'b1, 32'd5,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0};
    vecs[1]  = '{1'b0, 32'd5,    32'h0,        32'hDEADBEEF, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'd0,    32'h12345678, 32'h12345678, 1'b0, 0};
    vecs[3]  = '{1'b1, 32'd1023, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0};
    vecs[4]  = '{1'b0, 32'd1023, 32'h0,        32'hA5A5A5A5, 1'b0, 4};
    vecs[5]  = '{1'b0, 32'd0,    32'h0,        32'h12345678, 1'b0, 1};
    vecs[6]  = '{1'b0, 32'd1024, 32'h0,        ACHK ? 32'h0 : 32'h12345678, ACHK, 0};
    vecs[7]  = '{1'b1, 32'd6,    32'h00000001, 32'h00000001, 1'b0, 0};
    vecs[8]  = '{1'b1, 32'd1030, 32'hCAFEF00D, ACHK ? 32'h0 : 32'hCAFEF00D, ACHK, 0};
    vecs[9]  = '{1'b0, 32'd6,    32'h0,        ACHK ? 32'h1 : 32'hCAFEF00D, 1'b0, 0};
    vecs[10] = '{1'b1, 32'd5,    32'h00000000, 32'h00000000, 1'b0, 0};
    vecs[11] = '{1'b0, 32'd5,    32'h0,        32'h00000000, 1'b0, 2};

    // Asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs(0, "por0");
    chk_reset_outputs(1, "por1");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_por", {31'd0, req_ready[0]}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold, 1'b0);
    end

    // Reset during WAIT of a store: outputs clear at once and the store is lost
    do_txn(0, 1'b1, 32'd7, 32'h00000077, 32'h00000077, 1'b0, 0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd7;
    req_wdata[0] = 32'h00000011;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs(0, "rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);
    do_txn(0, 1'b0, 32'd7, 32'h0, 32'h00000077, 1'b0, 0, 1'b0);

    // A request held during WAIT must be ignored
    do_txn(0, 1'b1, 32'd9, 32'h00000099, 32'h00000099, 1'b0, 0, 1'b0);
    do_txn(0, 1'b1, 32'd8, 32'h00000088, 32'h00000088, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("no_second_resp", {31'd0, resp_valid[0]}, 32'd0);
    do_txn(0, 1'b0, 32'd9, 32'h0, 32'h00000099, 1'b0, 0, 1'b0);
    do_txn(0, 1'b0, 32'd8, 32'h0, 32'h00000088, 1'b0, 0, 1'b0);

    // Zero wait states
    do_txn(1, 1'b1, 32'd3, 32'h00000ABC, 32'h00000ABC, 1'b0, 0, 1'b0);
    do_txn(1, 1'b0, 32'd3, 32'h0,        32'h00000ABC, 1'b0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 2, legal 0..15, meaning extra cycles between request accept and response.
REQ-003 SHALL have port clk1, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit, initiator request present.
REQ-006 SHALL have port req_ready, output, 1 bit, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit, 1 = store, 0 = load or fetch.
REQ-008 SHALL have port req_addr, input, 32 bits, word address.
REQ-009 SHALL have port req_wdata, input, 32 bits, store data.
REQ-010 SHALL have port resp_valid, output, 1 bit, response present.
REQ-011 SHALL have port resp_ready, input, 1 bit, initiator takes the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits, read data, or echoed store data for a store.
REQ-013 SHALL have port resp_err, output, 1 bit, address error flag, valid with resp_valid.

Function
REQ-014 SHALL implement states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL drive resp_valid=1 only in RESP.
REQ-017 SHALL accept a request on an edge where req_valid=1 and req_ready=1, and latch req_we, req_addr and req_wdata.
REQ-018 SHALL go IDLE->WAIT on accept when WAIT_STATES>0, loading the wait counter with WAIT_STATES-1.
REQ-019 SHALL go IDLE->RESP on accept when WAIT_STATES=0.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-021 SHALL make resp_valid rise exactly WAIT_STATES+1 cycles after the accept edge.
REQ-022 SHALL commit a store (mem[addr] <= wdata) on the edge entering RESP; never earlier.
REQ-023 SHALL capture resp_rdata on the edge entering RESP: mem[addr] for a load, latched wdata for a store.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then go to IDLE.
REQ-025 SHALL ignore req_valid outside IDLE; no queuing; one transaction in flight; minimum period WAIT_STATES+2 cycles.
REQ-026 SHALL give read-after-write ordering: a load to an address returns data stored by any earlier completed store.
REQ-027 SHALL ignore req_we, req_addr and req_wdata when no accept occurs.

Reset
REQ-028 SHALL, on rst=1, force state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0 and resp_err=0 immediately, regardless of clk1.
REQ-029 SHALL make req_ready=1 from the first edge after rst deasserts.
REQ-030 SHALL NOT clear memory contents on reset.
REQ-031 SHALL discard a store interrupted by reset in WAIT; memory is unchanged.

Configuration
REQ-032 SHALL use macro MIPS_MEM_RESP_ADDR_CHECK_EN.
REQ-033 SHALL, when the macro is defined, set resp_err=1 for req_addr >= DEPTH; the store is suppressed and resp_rdata=0; timing is unchanged.
REQ-034 SHALL, when the macro is undefined, use address = req_addr modulo DEPTH (wrap-around) and tie resp_err to 0.

Verification
REQ-035 SHALL cover, with WAIT_STATES=2: store addr 5 data 0xDEADBEEF accepted at cycle 0 -> resp_valid at cycle 3 with rdata 0xDEADBEEF; load addr 5 -> rdata 0xDEADBEEF.
REQ-036 SHALL cover, with WAIT_STATES=0: load accepted at cycle 0 -> resp_valid at cycle 1; req_ready=0 at cycle 1.
REQ-037 SHALL cover resp_ready held 0 for 4 cycles in RESP -> resp_valid and resp_rdata stable and req_ready=0 throughout; IDLE one edge after resp_ready=1.
REQ-038 SHALL cover rst pulsed during WAIT of store addr 7 data 0x11 -> outputs 0 at once; later load addr 7 returns its prior value.
REQ-039 SHALL cover load addr 1024 (DEPTH=1024): with the macro -> resp_err=1 and rdata=0; without it -> rdata = mem[0], resp_err=0.
REQ-040 SHALL cover req_valid=1 asserted during WAIT with a different addr -> ignored; only the first transaction completes.
